// File: rtl/ds_input_pkg.sv
// Shared constants and helpers for the delta-sigma input core.
package ds_input_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned DS_DATA_WIDTH_MAX   = 64;

  // Counter width able to hold 0..n, matching the clock detector's rule.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/ds_sync_edge.sv
// Synchronizes the modulator clock and data into aclk and strobes on the sampling edge.
module ds_sync_edge
  import ds_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = SYNC_STAGES_DEFAULT,
  parameter bit          SAMPLE_ON_FALLING = 1'b0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic ds_clk,
  input  logic ds_data,
  output logic edge_pulse,
  output logic data_sync
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   edge_q;
  logic                   data_q;
  logic                   clk_now;
  logic                   edge_det;

  assign clk_now  = clk_sync_q[SYNC_STAGES-1];
  assign edge_det = SAMPLE_ON_FALLING ? (~clk_now & clk_prev_q) : (clk_now & ~clk_prev_q);

  // Data is delayed alongside the registered strobe so both stay aligned.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      edge_q      <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ds_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ds_data};
      clk_prev_q  <= clk_now;
      edge_q      <= edge_det;
      data_q      <= data_sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = edge_q;
  assign data_sync  = data_q;

endmodule

// File: rtl/ds_bitstream_packer.sv
// Packs the synchronized modulator bitstream MSB-first into words on an AXI-Stream master,
// with packet framing via tlast and a sticky overflow flag for dropped words.
module ds_bitstream_packer
  import ds_input_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned PACKET_WORDS      = 64,
  parameter bit          SAMPLE_ON_FALLING = 1'b0,
  parameter int unsigned SYNC_STAGES       = SYNC_STAGES_DEFAULT
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  ds_clk,
  input  logic                  ds_data,
  input  logic                  clk_detect,
  input  logic                  enable,
  input  logic                  overflow_clr,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  overflow
);

  localparam int unsigned BitCntW  = cnt_width(DATA_WIDTH);
  localparam int unsigned WordCntW = cnt_width(PACKET_WORDS);
  localparam logic [BitCntW-1:0]  BitLast  = BitCntW'(DATA_WIDTH - 1);
  localparam logic [WordCntW-1:0] WordLast = WordCntW'(PACKET_WORDS - 1);

  logic                  edge_pulse;
  logic                  data_sync;
  logic                  capture;
  logic                  gate_off;
  logic                  slot_free;
  logic [DATA_WIDTH-1:0] word;

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WordCntW-1:0]   word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  overflow_q, overflow_d;
  logic                  ovf_set;

  ds_sync_edge #(
    .SYNC_STAGES      (SYNC_STAGES),
    .SAMPLE_ON_FALLING(SAMPLE_ON_FALLING)
  ) u_sync_edge (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .ds_clk    (ds_clk),
    .ds_data   (ds_data),
    .edge_pulse(edge_pulse),
    .data_sync (data_sync)
  );

  assign gate_off  = ~(enable & clk_detect);
  assign capture   = edge_pulse & ~gate_off;
  assign slot_free = ~tvalid_q | m_axis_tready;
  assign word      = {shreg_q[DATA_WIDTH-2:0], data_sync};

  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    ovf_set    = 1'b0;

    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

    // Losing the clock or enable discards the partial word and realigns packets;
    // a pending output word is left untouched.
    if (gate_off) begin
      shreg_d    = '0;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (capture) begin
      shreg_d = word;
      if (bit_cnt_q == BitLast) begin
        bit_cnt_d = '0;
        if (slot_free) begin
          tdata_d    = word;
          tvalid_d   = 1'b1;
          tlast_d    = (word_cnt_q == WordLast);
          word_cnt_d = (word_cnt_q == WordLast) ? '0 : word_cnt_q + WordCntW'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BitCntW'(1);
      end
    end

    overflow_d = ovf_set ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_ds_bitstream_packer.sv
// Scoreboard bench for ds_bitstream_packer: random words against a word-level reference model.
module tb_ds_bitstream_packer;

  localparam int DW = 8;
  localparam int PW = 4;
  localparam int SS = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          ds_clk = 1'b0;
  logic          ds_data = 1'b0;
  logic          clk_detect = 1'b0;
  logic          enable = 1'b0;
  logic          overflow_clr = 1'b0;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          overflow;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int half = 4;

  // Expected beats: {data, last}.
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] m_part = '0;
  int            m_nbits = 0;
  int            m_idx = 0;
  bit            m_busy = 1'b0;

  ds_bitstream_packer #(
    .DATA_WIDTH       (DW),
    .PACKET_WORDS     (PW),
    .SAMPLE_ON_FALLING(1'b0),
    .SYNC_STAGES      (SS)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .ds_clk       (ds_clk),
    .ds_data      (ds_data),
    .clk_detect   (clk_detect),
    .enable       (enable),
    .overflow_clr (overflow_clr),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .overflow     (overflow)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: every DW accepted bits form a word; packet position counts delivered words only.
  task automatic model_bit(input bit b);
    m_part = {m_part[DW-2:0], b};
    m_nbits++;
    if (m_nbits == DW) begin
      m_nbits = 0;
      if (!m_busy) begin
        exp_q.push_back({m_part, (m_idx == PW - 1)});
        m_idx  = (m_idx + 1) % PW;
        m_busy = !tready;
      end
    end
  endtask

  task automatic model_realign();
    m_part  = '0;
    m_nbits = 0;
    m_idx   = 0;
  endtask

  task automatic send_bit(input bit b);
    @(posedge aclk); #1;
    ds_clk  = 1'b0;
    ds_data = b;
    repeat (half) @(posedge aclk);
    #1;
    ds_clk = 1'b1;
    model_bit(b);
    repeat (half - 1) @(posedge aclk);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge aclk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pop and compare on every handshake.
  always @(negedge aclk) begin
    if (aresetn && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("tdata", 64'(tdata), 64'(e[DW:1]));
        check("tlast", 64'(tlast), 64'(e[0]));
      end
    end
  end

  initial begin
    logic [DW-1:0] basic;
    logic [DW-1:0] w;
    int lat;

    repeat (3) @(posedge aclk);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    clk_detect = 1'b1;
    enable = 1'b1;
    tready = 1'b1;

    // Basic pack with latency and single-cycle valid checks on the final bit.
    basic = 8'hB2;
    for (int i = DW - 1; i >= 1; i--) send_bit(basic[i]);
    @(posedge aclk); #1;
    ds_clk  = 1'b0;
    ds_data = basic[0];
    repeat (half) @(posedge aclk);
    #1;
    ds_clk = 1'b1;
    model_bit(basic[0]);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge aclk); #1;
      lat++;
      if (tvalid) break;
    end
    check("valid_latency", 64'(lat), 64'(SS + 2));
    @(posedge aclk); #1;
    check("valid_one_cycle", 64'(tvalid), 64'd0);
    drain();

    // Packet framing over 12 random words.
    for (int n = 0; n < 12; n++) send_word(DW'($urandom));
    repeat (8) @(posedge aclk);
    drain();

    // Backpressure: first word held, second dropped.
    tready = 1'b0;
    w = DW'($urandom);
    send_word(w);
    send_word(DW'($urandom));
    repeat (8) @(posedge aclk);
    #1;
    check("bp_overflow", 64'(overflow), 64'd1);
    check("bp_tvalid", 64'(tvalid), 64'd1);
    check("bp_held_data", 64'(tdata), 64'(w));
    @(posedge aclk); #1;
    tready = 1'b1;
    m_busy = 1'b0;
    drain();
    check("ovf_sticky", 64'(overflow), 64'd1);
    @(posedge aclk); #1;
    overflow_clr = 1'b1;
    @(posedge aclk); #1;
    overflow_clr = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Clock loss mid-word discards partial bits and restarts packet count.
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    repeat (6) @(posedge aclk);
    #1;
    clk_detect = 1'b0;
    model_realign();
    repeat (4) @(posedge aclk);
    #1;
    clk_detect = 1'b1;
    send_word(8'hFF);
    for (int n = 0; n < 4; n++) send_word(DW'($urandom));
    repeat (8) @(posedge aclk);
    drain();

    // Back-to-back at aclk/4 for 100 words.
    half = 2;
    for (int n = 0; n < 100; n++) send_word(DW'($urandom));
    repeat (8) @(posedge aclk);
    drain();
    check("b2b_no_overflow", 64'(overflow), 64'd0);
    half = 4;

    // Async reset mid-word with a pending beat.
    tready = 1'b0;
    send_word(DW'($urandom) | 8'h01);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    @(posedge aclk); #1;
    ds_clk = 1'b0;
    repeat (8) @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check("arst_tvalid", 64'(tvalid), 64'd0);
    check("arst_tdata", 64'(tdata), 64'd0);
    check("arst_tlast", 64'(tlast), 64'd0);
    exp_q.delete();
    model_realign();
    m_busy = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    tready = 1'b1;
    send_word(DW'($urandom));
    repeat (8) @(posedge aclk);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
